// File: rtl/tft_bus_writer_if.sv
// Bundle between the frame renderer and tft_bus_writer, plus the TFT
// controller pins driven by the writer.
//
// Handshake: qvga_pclk_i and qvga_reset_i are edge-triggered requests. A rising
// edge seen while the writer is idle starts one transaction and qvga_cyc_o goes
// high on that same clock edge. qvga_cyc_o stays high until the transaction has
// finished and both request lines are low again. qvga_dat_i must be valid on the
// cycle where qvga_pclk_i rises. Edges that arrive while qvga_cyc_o is high are
// dropped. On the TFT side, the controller latches tft_d_o/tft_dc_o on the rising
// edge of tft_wr_n_o while tft_cs_n_o is low.
interface tft_bus_writer_if #(
    parameter int DBUS = 16
);
    logic [DBUS-1:0] qvga_dat_i;
    logic            qvga_pclk_i;
    logic            qvga_reset_i;
    logic            qvga_cyc_o;
    logic [DBUS-1:0] tft_d_o;
    logic            tft_cs_n_o;
    logic            tft_dc_o;
    logic            tft_wr_n_o;
    logic            tft_rd_n_o;

    // Writer side: consumes requests, drives busy and the TFT pins.
    modport slave (
        input  qvga_dat_i, qvga_pclk_i, qvga_reset_i,
        output qvga_cyc_o, tft_d_o, tft_cs_n_o, tft_dc_o, tft_wr_n_o, tft_rd_n_o
    );

    // Renderer side: issues requests and watches busy.
    modport master (
        output qvga_dat_i, qvga_pclk_i, qvga_reset_i,
        input  qvga_cyc_o, tft_d_o, tft_cs_n_o, tft_dc_o, tft_wr_n_o, tft_rd_n_o
    );
endinterface

// File: rtl/tft_bus_writer.sv
// tft_bus_writer: turns renderer pixel/frame requests into 8080-style TFT
// writes. A frame request emits the window-setup + memory-write command
// sequence, and a pixel request emits one data write.
// Optional feature macro: TFT_WINDOW_CMD_EN. When it is defined, the frame
// sequence also programs the column/page window from width/height (11 words).
// When it is undefined, only the memory-write command 0x002C is sent.
// dbg_state exposes the FSM state: 0 IDLE, 1 LOAD, 2 WR_LO, 3 WR_HI, 4 DONE.
module tft_bus_writer #(
    parameter int RANGE   = 9,
    parameter int DBUS    = 16,
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [RANGE-1:0] width,
    input  logic [RANGE-1:0] height,
    tft_bus_writer_if.slave  bus,
    output logic [2:0]       dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WR_LO = 3'd2,
        S_WR_HI = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int CW = 8;
    localparam logic [CW-1:0] LO_LAST = CW'(WR_LOW - 1);
    localparam logic [CW-1:0] HI_LAST = CW'(WR_HIGH - 1);
`ifdef TFT_WINDOW_CMD_EN
    localparam logic [3:0] SEQ_LAST = 4'd10;
`else
    localparam logic [3:0] SEQ_LAST = 4'd0;
`endif

    state_t          state_q, state_n;
    logic [3:0]      idx_q, idx_n;         // position within the setup sequence
    logic            seq_q, seq_n;         // setup words still to send
    logic            pix_q, pix_n;         // latched pixel still to send
    logic [DBUS-1:0] pix_dat_q, pix_dat_n;
    logic [DBUS-1:0] d_q, d_n;
    logic            dc_q, dc_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            pclk_q, reset_q;
    logic            pclk_req, reset_req;
    logic            load;
    logic [15:0]     seq_word;
    logic            seq_dc;

    assign pclk_req  = bus.qvga_pclk_i  & ~pclk_q;
    assign reset_req = bus.qvga_reset_i & ~reset_q;

`ifdef TFT_WINDOW_CMD_EN
    logic [RANGE-1:0] w_m1, h_m1;
    logic [15:0]      w16, h16;
    // Window end coordinates wrap modulo 2^RANGE, so width=0 gives the all-ones column.
    assign w_m1 = width - RANGE'(1);
    assign h_m1 = height - RANGE'(1);
    assign w16  = 16'(w_m1);
    assign h16  = 16'(h_m1);

    // Setup word and D/C for the current sequence index.
    always_comb begin
        seq_word = 16'h002C;
        seq_dc   = 1'b0;
        case (idx_q)
            4'd0:                      begin seq_word = 16'h002A;          seq_dc = 1'b0; end
            4'd1, 4'd2, 4'd6, 4'd7:    begin seq_word = 16'h0000;          seq_dc = 1'b1; end
            4'd3:                      begin seq_word = w16 >> 8;          seq_dc = 1'b1; end
            4'd4:                      begin seq_word = w16 & 16'h00FF;    seq_dc = 1'b1; end
            4'd5:                      begin seq_word = 16'h002B;          seq_dc = 1'b0; end
            4'd8:                      begin seq_word = h16 >> 8;          seq_dc = 1'b1; end
            4'd9:                      begin seq_word = h16 & 16'h00FF;    seq_dc = 1'b1; end
            default:                   begin seq_word = 16'h002C;          seq_dc = 1'b0; end
        endcase
    end
`else
    // Frame dimensions play no part when the window is not programmed.
    logic unused_dims;
    assign unused_dims = ^{width, height};

    // The only setup word is the memory-write command.
    always_comb begin
        seq_word = 16'h002C;
        seq_dc   = 1'b0;
    end
`endif

    // State register, word/sequence bookkeeping and request edge detectors.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            seq_q     <= 1'b0;
            pix_q     <= 1'b0;
            pix_dat_q <= '0;
            d_q       <= '0;
            dc_q      <= 1'b1;
            cnt_q     <= '0;
            pclk_q    <= 1'b0;
            reset_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            seq_q     <= seq_n;
            pix_q     <= pix_n;
            pix_dat_q <= pix_dat_n;
            d_q       <= d_n;
            dc_q      <= dc_n;
            cnt_q     <= cnt_n;
            pclk_q    <= bus.qvga_pclk_i;
            reset_q   <= bus.qvga_reset_i;
        end
    end

    // Next-state logic. A new word is loaded from LOAD, or straight from the end of
    // WR_HI, so that back-to-back words keep a WR_LOW+WR_HIGH period.
    always_comb begin
        state_n   = state_q;
        idx_n     = idx_q;
        seq_n     = seq_q;
        pix_n     = pix_q;
        pix_dat_n = pix_dat_q;
        d_n       = d_q;
        dc_n      = dc_q;
        cnt_n     = cnt_q;
        load      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (reset_req || pclk_req) begin
                    state_n = S_LOAD;
                    seq_n   = reset_req;
                    pix_n   = pclk_req;
                    idx_n   = '0;
                    if (pclk_req) pix_dat_n = bus.qvga_dat_i;
                end
            end
            S_LOAD: begin
                load    = 1'b1;
                cnt_n   = '0;
                state_n = S_WR_LO;
            end
            S_WR_LO: begin
                if (cnt_q == LO_LAST) begin
                    cnt_n   = '0;
                    state_n = S_WR_HI;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            S_WR_HI: begin
                if (cnt_q == HI_LAST) begin
                    cnt_n = '0;
                    if (seq_q || pix_q) begin
                        load    = 1'b1;
                        state_n = S_WR_LO;
                    end else begin
                        state_n = S_DONE;
                    end
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (!bus.qvga_pclk_i && !bus.qvga_reset_i) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Setup words always go out before a pixel latched in the same request.
        if (load) begin
            if (seq_q) begin
                d_n  = DBUS'(seq_word);
                dc_n = seq_dc;
                if (idx_q == SEQ_LAST) begin
                    seq_n = 1'b0;
                    idx_n = '0;
                end else begin
                    idx_n = idx_q + 4'd1;
                end
            end else begin
                d_n   = pix_dat_q;
                dc_n  = 1'b1;
                pix_n = 1'b0;
            end
        end
    end

    assign bus.qvga_cyc_o = (state_q != S_IDLE);
    assign bus.tft_cs_n_o = !((state_q == S_WR_LO) || (state_q == S_WR_HI));
    assign bus.tft_wr_n_o = (state_q != S_WR_LO);
    assign bus.tft_rd_n_o = 1'b1;
    assign bus.tft_d_o    = d_q;
    assign bus.tft_dc_o   = dc_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_tft_bus_writer.sv
// Directed testbench for tft_bus_writer. Words written to the TFT are captured
// on each rising edge of wr_n as {dc, d} and compared with hand-built expected
// lists. Expectations follow TFT_WINDOW_CMD_EN when it is defined.
`timescale 1ns/1ps
module tb_tft_bus_writer;
  localparam int DBUS  = 16;
  localparam int RANGE = 9;
  localparam int PER   = 4;   // WR_LOW + WR_HIGH with the defaults below

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [RANGE-1:0] width = 9'd240;
  logic [RANGE-1:0] height = 9'd320;
  logic [2:0]       dbg_state;
  int               n_vec = 0;
  int               n_err = 0;

  tft_bus_writer_if #(.DBUS(DBUS)) bus ();

  tft_bus_writer #(.RANGE(RANGE), .DBUS(DBUS), .WR_LOW(2), .WR_HIGH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .width(width), .height(height),
    .bus(bus), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk_i = ~clk_i;

  // capture monitor: one {dc,d} entry per wr_n rising edge, plus a stability count
  logic [16:0] cap_q[$];
  logic [16:0] exp_q[$];
  logic        prev_wr_n = 1'b1;
  logic [16:0] at_fall = '0;
  int          unstable_cnt = 0;
  always @(negedge clk_i) begin
    prev_wr_n <= bus.tft_wr_n_o;
    if (prev_wr_n && !bus.tft_wr_n_o) at_fall <= {bus.tft_dc_o, bus.tft_d_o};
    if (!prev_wr_n && bus.tft_wr_n_o) begin
      cap_q.push_back({bus.tft_dc_o, bus.tft_d_o});
      if ({bus.tft_dc_o, bus.tft_d_o} !== at_fall) unstable_cnt <= unstable_cnt + 1;
    end
  end

  // driver: pulse the requested lines for one cycle and follow the transaction to IDLE
  task automatic do_txn(input bit rq_rst, input bit rq_pclk, input logic [15:0] dat,
                        output int len, output int cyc_hi, output int cs_lo,
                        output int wr_lo, output bit first_ok, output bit timeout);
    cap_q.delete();
    bus.qvga_dat_i = dat; bus.qvga_reset_i = rq_rst; bus.qvga_pclk_i = rq_pclk;
    len = -1; cyc_hi = 0; cs_lo = 0; wr_lo = 0; first_ok = 1'b0; timeout = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk_i);
      if (i == 1) begin
        bus.qvga_reset_i = 1'b0; bus.qvga_pclk_i = 1'b0;
        first_ok = bus.qvga_cyc_o && bus.tft_cs_n_o && bus.tft_wr_n_o;
      end
      if (i == 2) first_ok = first_ok && !bus.tft_cs_n_o && !bus.tft_wr_n_o;
      if (len < 0 && dbg_state == 3'd4) len = i - 1;
      if (!bus.qvga_cyc_o) begin timeout = 1'b0; break; end
      cyc_hi++;
      if (!bus.tft_cs_n_o) cs_lo++;
      if (!bus.tft_wr_n_o) wr_lo++;
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; bus.qvga_pclk_i = 1'b0; bus.qvga_reset_i = 1'b0; bus.qvga_dat_i = '0;
    repeat (3) @(negedge clk_i);
    n_vec++;
    if ({bus.qvga_cyc_o, bus.tft_cs_n_o, bus.tft_dc_o, bus.tft_wr_n_o, bus.tft_rd_n_o} !== 5'b01111) begin
      n_err++; $display("FAIL reset_ctrl: cyc,cs_n,dc,wr_n,rd_n got %b want 01111",
        {bus.qvga_cyc_o, bus.tft_cs_n_o, bus.tft_dc_o, bus.tft_wr_n_o, bus.tft_rd_n_o});
    end
    n_vec++;
    if (bus.tft_d_o !== 16'h0000) begin n_err++; $display("FAIL reset_d: got %h want 0000", bus.tft_d_o); end
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_vec++;
    if (bus.qvga_cyc_o !== 1'b0) begin n_err++; $display("FAIL reset_idle_cyc: got %b want 0", bus.qvga_cyc_o); end
  endtask

  task automatic test_pixel;
    int len, cyc_hi, cs_lo, wr_lo, u0; bit first_ok, to;
    u0 = unstable_cnt;
    do_txn(1'b0, 1'b1, 16'hF81F, len, cyc_hi, cs_lo, wr_lo, first_ok, to);
    n_vec++; if (to) begin n_err++; $display("FAIL pixel_timeout: cyc_o still high after 200 cycles"); end
    n_vec++; if (!first_ok) begin n_err++; $display("FAIL pixel_timing: cyc at k / cs_n,wr_n low at k+1 not seen"); end
    n_vec++; if (len !== 5) begin n_err++; $display("FAIL pixel_len: got %0d want 5", len); end
    n_vec++; if (cyc_hi !== 6) begin n_err++; $display("FAIL pixel_cyc_hi: got %0d want 6", cyc_hi); end
    n_vec++; if (cs_lo !== 4) begin n_err++; $display("FAIL pixel_cs_lo: got %0d want 4", cs_lo); end
    n_vec++; if (wr_lo !== 2) begin n_err++; $display("FAIL pixel_wr_lo: got %0d want 2", wr_lo); end
    n_vec++;
    if (cap_q.size() != 1 || cap_q[0] !== 17'h1F81F) begin
      n_err++; $display("FAIL pixel_word: got %0d words first %h want 1 word 1f81f", cap_q.size(), cap_q[0]);
    end
    n_vec++; if (unstable_cnt != u0) begin n_err++; $display("FAIL pixel_stable: d/dc changed while wr_n low"); end
  endtask

  task automatic test_pclk_hold;
    bus.qvga_dat_i = 16'h07E0; bus.qvga_pclk_i = 1'b1;
    cap_q.delete();
    repeat (12) @(negedge clk_i);
    n_vec++;
    if (bus.qvga_cyc_o !== 1'b1 || dbg_state !== 3'd4) begin
      n_err++; $display("FAIL hold_done: cyc %b state %0d want 1 / 4", bus.qvga_cyc_o, dbg_state);
    end
    bus.qvga_pclk_i = 1'b0;
    @(negedge clk_i);
    n_vec++; if (bus.qvga_cyc_o !== 1'b0) begin n_err++; $display("FAIL hold_cyc_fall: got %b want 0", bus.qvga_cyc_o); end
    n_vec++;
    if (cap_q.size() != 1 || cap_q[0] !== 17'h107E0) begin
      n_err++; $display("FAIL hold_word: got %0d words first %h want 1 word 107e0", cap_q.size(), cap_q[0]);
    end
  endtask

  // frame sequence with a given width/height and expected column/page end bytes
  task automatic test_setup(input logic [RANGE-1:0] w, input logic [RANGE-1:0] h,
                            input logic [15:0] wh, input logic [15:0] wl,
                            input logic [15:0] hh, input logic [15:0] hl,
                            input bit with_pix, input string tag);
    int len, cyc_hi, cs_lo, wr_lo, nw; bit first_ok, to;
    width = w; height = h;
`ifdef TFT_WINDOW_CMD_EN
    exp_q = '{17'h0002A, 17'h10000, 17'h10000, {1'b1, wh}, {1'b1, wl},
              17'h0002B, 17'h10000, 17'h10000, {1'b1, hh}, {1'b1, hl}, 17'h0002C};
`else
    exp_q = '{17'h0002C};
    if (wh === 16'hxxxx || wl === 16'hxxxx || hh === 16'hxxxx || hl === 16'hxxxx) exp_q.delete();
`endif
    if (with_pix) exp_q.push_back(17'h11234);
    nw = exp_q.size();
    do_txn(1'b1, with_pix, 16'h1234, len, cyc_hi, cs_lo, wr_lo, first_ok, to);
    n_vec++; if (to) begin n_err++; $display("FAIL %s_timeout: cyc_o still high after 200 cycles", tag); end
    n_vec++; if (!first_ok) begin n_err++; $display("FAIL %s_timing: first write not at k+1", tag); end
    n_vec++; if (len !== 1 + PER * nw) begin n_err++; $display("FAIL %s_len: got %0d want %0d", tag, len, 1 + PER * nw); end
    n_vec++; if (cyc_hi !== 2 + PER * nw) begin n_err++; $display("FAIL %s_cyc_hi: got %0d want %0d", tag, cyc_hi, 2 + PER * nw); end
    n_vec++; if (cs_lo !== PER * nw) begin n_err++; $display("FAIL %s_cs_lo: got %0d want %0d", tag, cs_lo, PER * nw); end
    n_vec++; if (cap_q.size() != nw) begin n_err++; $display("FAIL %s_count: got %0d words want %0d", tag, cap_q.size(), nw); end
    foreach (exp_q[j]) begin
      n_vec++;
      if (j >= cap_q.size() || cap_q[j] !== exp_q[j]) begin
        n_err++; $display("FAIL %s_word%0d: got %h want %h", tag, j, (j < cap_q.size()) ? cap_q[j] : 17'h0, exp_q[j]);
      end
    end
  endtask

  task automatic test_abort;
    int target, falls, len, cyc_hi, cs_lo, wr_lo; bit first_ok, to, prev;
`ifdef TFT_WINDOW_CMD_EN
    target = 5;
`else
    target = 1;
`endif
    width = 9'd240; height = 9'd320;
    bus.qvga_reset_i = 1'b1; falls = 0; prev = 1'b1;
    for (int i = 0; i < 100 && falls < target; i++) begin
      @(negedge clk_i);
      bus.qvga_reset_i = 1'b0;
      if (prev && !bus.tft_wr_n_o) falls++;
      prev = bus.tft_wr_n_o;
    end
    n_vec++; if (falls != target) begin n_err++; $display("FAIL abort_reach: got %0d writes want %0d", falls, target); end
    rst_i = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if ({bus.qvga_cyc_o, bus.tft_cs_n_o, bus.tft_wr_n_o, bus.tft_dc_o} !== 4'b0111 || bus.tft_d_o !== 16'h0) begin
      n_err++; $display("FAIL abort_outputs: cyc,cs_n,wr_n,dc got %b d %h want 0111 d 0000",
        {bus.qvga_cyc_o, bus.tft_cs_n_o, bus.tft_wr_n_o, bus.tft_dc_o}, bus.tft_d_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    do_txn(1'b0, 1'b1, 16'hA5A5, len, cyc_hi, cs_lo, wr_lo, first_ok, to);
    n_vec++;
    if (to || len !== 5 || cap_q.size() != 1 || cap_q[0] !== 17'h1A5A5) begin
      n_err++; $display("FAIL abort_then_pixel: len %0d words %0d first %h want 5 / 1 / 1a5a5", len, cap_q.size(), cap_q[0]);
    end
  endtask

  task automatic test_ignored;
    int waited;
    cap_q.delete();
    bus.qvga_dat_i = 16'h1111; bus.qvga_pclk_i = 1'b1;
    @(negedge clk_i); bus.qvga_pclk_i = 1'b0;
    @(negedge clk_i); bus.qvga_dat_i = 16'h2222; bus.qvga_pclk_i = 1'b1; bus.qvga_reset_i = 1'b1;
    @(negedge clk_i); bus.qvga_pclk_i = 1'b0; bus.qvga_reset_i = 1'b0;
    waited = 0;
    while (bus.qvga_cyc_o && waited < 200) begin @(negedge clk_i); waited++; end
    n_vec++; if (waited >= 200) begin n_err++; $display("FAIL ignored_timeout: cyc_o still high"); end
    repeat (4) @(negedge clk_i);
    n_vec++; if (bus.qvga_cyc_o !== 1'b0) begin n_err++; $display("FAIL ignored_queued: cyc got %b want 0", bus.qvga_cyc_o); end
    n_vec++;
    if (cap_q.size() != 1 || cap_q[0] !== 17'h11111) begin
      n_err++; $display("FAIL ignored_words: got %0d words first %h want 1 word 11111", cap_q.size(), cap_q[0]);
    end
  endtask

  task automatic test_back_to_back;
    int len, cyc_hi, cs_lo, wr_lo; bit first_ok, to;
    do_txn(1'b0, 1'b1, 16'h0F0F, len, cyc_hi, cs_lo, wr_lo, first_ok, to);
    n_vec++;
    if (to || cap_q.size() != 1 || cap_q[0] !== 17'h10F0F) begin
      n_err++; $display("FAIL b2b_first: words %0d first %h want 1 / 10f0f", cap_q.size(), cap_q[0]);
    end
    do_txn(1'b0, 1'b1, 16'hF0F0, len, cyc_hi, cs_lo, wr_lo, first_ok, to);
    n_vec++;
    if (to || !first_ok || len !== 5 || cap_q.size() != 1 || cap_q[0] !== 17'h1F0F0) begin
      n_err++; $display("FAIL b2b_second: ok %b len %0d words %0d first %h want 1 / 5 / 1 / 1f0f0",
        first_ok, len, cap_q.size(), cap_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_pclk_hold();
    test_setup(9'd240, 9'd320, 16'h0000, 16'h00EF, 16'h0001, 16'h003F, 1'b0, "setup");
    test_setup(9'd0, 9'd1, 16'h0001, 16'h00FF, 16'h0000, 16'h0000, 1'b0, "width_zero");
    test_setup(9'd240, 9'd320, 16'h0000, 16'h00EF, 16'h0001, 16'h003F, 1'b1, "both_edges");
    test_abort();
    test_ignored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
